digital_lock_param: RTL and testbench

//  Parametrised code lock: accepts a CODE_LEN-digit sequence of DIGIT_W-bit digits, one per x_valid strobe.

---
 rtl/digital_lock_param_if.sv | 24 ++
 rtl/digital_lock_param.sv | 215 +++++++++++++++++++++
 tb/tb_digital_lock_param.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/digital_lock_param_if.sv
// Keypad-to-lock bus: digit strobe in, unlock/alarm/fail count out.
// Prog signals exist only when DIGITAL_LOCK_PROG_EN is defined.
interface digital_lock_param_if #(
    parameter int DIGIT_W   = 3,
    parameter int MAX_FAILS = 3
);
    localparam int FCW = $clog2(MAX_FAILS + 1);

    logic [DIGIT_W-1:0] x;
    logic               x_valid;
    logic               y;
    logic               alarm;
    logic [FCW-1:0]     fail_cnt;
`ifdef DIGITAL_LOCK_PROG_EN
    logic               prog_req;
    logic               prog_done;

    modport master (output x, x_valid, prog_req, input y, alarm, fail_cnt, prog_done);
    modport slave  (input x, x_valid, prog_req, output y, alarm, fail_cnt, prog_done);
`else
    modport master (output x, x_valid, input y, alarm, fail_cnt);
    modport slave  (input x, x_valid, output y, alarm, fail_cnt);
`endif
endinterface

// File: rtl/digital_lock_param.sv
// Parametrised code lock with failure lockout and partial-entry timeout.
// Define DIGITAL_LOCK_PROG_EN to allow reprogramming the code from the UNLOCK state.
module digital_lock_param #(
    parameter int                          DIGIT_W        = 3,
    parameter int                          CODE_LEN       = 3,
    parameter logic [DIGIT_W*CODE_LEN-1:0] CODE           = 9'b011_111_101,
    parameter int                          MAX_FAILS      = 3,
    parameter int                          UNLOCK_CYCLES  = 4,
    parameter int                          LOCKOUT_CYCLES = 16,
    parameter int                          TIMEOUT_CYCLES = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    digital_lock_param_if.slave bus
);
    localparam int CW       = DIGIT_W * CODE_LEN;
    localparam int FCW      = $clog2(MAX_FAILS + 1);
    localparam int IW       = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int HOLD_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
    localparam int TW       = $clog2(HOLD_MAX + 1);
    localparam int OW       = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_UNLOCK,
`ifdef DIGITAL_LOCK_PROG_EN
        ST_LOCKOUT,
        ST_PROG
`else
        ST_LOCKOUT
`endif
    } state_t;

    state_t         r_state, w_stateNext;
    logic [IW-1:0]  r_idx, w_idxNext;
    logic           r_err, w_errNext;
    logic [TW-1:0]  r_hold, w_holdNext;
    logic [OW-1:0]  r_idle, w_idleNext;
    logic           r_y, w_yNext;
    logic           r_alarm, w_alarmNext;
    logic [FCW-1:0] r_failCnt, w_failNext;

    logic [CW-1:0]      w_code;
    logic [DIGIT_W-1:0] w_codeDigits [CODE_LEN];
    logic [DIGIT_W-1:0] w_expDigit;
    logic               w_mismatch;
    logic               w_lastDigit;

`ifdef DIGITAL_LOCK_PROG_EN
    logic [CW-1:0] r_code, w_codeNext;
    logic [CW-1:0] r_newCode, w_newCodeNext;
    logic [CW-1:0] w_shiftIn;
    logic          r_progDone, w_progDoneNext;

    assign w_code        = r_code;
    assign w_shiftIn     = (r_newCode << DIGIT_W) | CW'(bus.x);
    assign bus.prog_done = r_progDone;
`else
    assign w_code = CODE;
`endif

    // Digit 0 of the entry sequence lives in the MSBs of the code word
    always_comb begin
        for (int i = 0; i < CODE_LEN; i++) begin
            w_codeDigits[i] = w_code[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
        end
    end

    assign w_expDigit  = w_codeDigits[r_idx];
    assign w_mismatch  = (bus.x != w_expDigit);
    assign w_lastDigit = (r_idx == IW'(CODE_LEN - 1));

    assign bus.y        = r_y;
    assign bus.alarm    = r_alarm;
    assign bus.fail_cnt = r_failCnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_ENTRY;
            r_idx      <= '0;
            r_err      <= 1'b0;
            r_hold     <= '0;
            r_idle     <= '0;
            r_y        <= 1'b0;
            r_alarm    <= 1'b0;
            r_failCnt  <= '0;
`ifdef DIGITAL_LOCK_PROG_EN
            r_code     <= CODE;
            r_newCode  <= '0;
            r_progDone <= 1'b0;
`endif
        end else begin
            r_state    <= w_stateNext;
            r_idx      <= w_idxNext;
            r_err      <= w_errNext;
            r_hold     <= w_holdNext;
            r_idle     <= w_idleNext;
            r_y        <= w_yNext;
            r_alarm    <= w_alarmNext;
            r_failCnt  <= w_failNext;
`ifdef DIGITAL_LOCK_PROG_EN
            r_code     <= w_codeNext;
            r_newCode  <= w_newCodeNext;
            r_progDone <= w_progDoneNext;
`endif
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_idxNext   = r_idx;
        w_errNext   = r_err;
        w_holdNext  = r_hold;
        w_idleNext  = r_idle;
        w_yNext     = r_y;
        w_alarmNext = r_alarm;
        w_failNext  = r_failCnt;
`ifdef DIGITAL_LOCK_PROG_EN
        w_codeNext     = r_code;
        w_newCodeNext  = r_newCode;
        w_progDoneNext = 1'b0;
`endif
        case (r_state)
            ST_ENTRY: begin
                if (bus.x_valid) begin
                    w_idleNext = '0;
                    if (w_lastDigit) begin
                        w_idxNext = '0;
                        w_errNext = 1'b0;
                        if (!(r_err || w_mismatch)) begin
                            w_stateNext = ST_UNLOCK;
                            w_yNext     = 1'b1;
                            w_failNext  = '0;
                            w_holdNext  = '0;
                        end else if (r_failCnt == FCW'(MAX_FAILS - 1)) begin
                            w_stateNext = ST_LOCKOUT;
                            w_alarmNext = 1'b1;
                            w_failNext  = FCW'(MAX_FAILS);
                            w_holdNext  = '0;
                        end else begin
                            w_failNext = r_failCnt + FCW'(1);
                        end
                    end else begin
                        w_idxNext = r_idx + IW'(1);
                        w_errNext = r_err | w_mismatch;
                    end
                end else if (r_idx != '0) begin
                    // Abandoned entry is dropped silently; it does not count as a failure
                    if (r_idle == OW'(TIMEOUT_CYCLES - 1)) begin
                        w_idxNext  = '0;
                        w_errNext  = 1'b0;
                        w_idleNext = '0;
                    end else begin
                        w_idleNext = r_idle + OW'(1);
                    end
                end
            end
            ST_UNLOCK: begin
`ifdef DIGITAL_LOCK_PROG_EN
                if (bus.prog_req) begin
                    w_stateNext = ST_PROG;
                    w_yNext     = 1'b0;
                    w_idxNext   = '0;
                    w_idleNext  = '0;
                    w_holdNext  = '0;
                end else
`endif
                if (r_hold == TW'(UNLOCK_CYCLES - 1)) begin
                    w_stateNext = ST_ENTRY;
                    w_yNext     = 1'b0;
                    w_holdNext  = '0;
                end else begin
                    w_holdNext = r_hold + TW'(1);
                end
            end
            ST_LOCKOUT: begin
                if (r_hold == TW'(LOCKOUT_CYCLES - 1)) begin
                    w_stateNext = ST_ENTRY;
                    w_alarmNext = 1'b0;
                    w_failNext  = '0;
                    w_holdNext  = '0;
                end else begin
                    w_holdNext = r_hold + TW'(1);
                end
            end
`ifdef DIGITAL_LOCK_PROG_EN
            ST_PROG: begin
                if (bus.x_valid) begin
                    w_idleNext    = '0;
                    w_newCodeNext = w_shiftIn;
                    if (w_lastDigit) begin
                        w_codeNext     = w_shiftIn;
                        w_progDoneNext = 1'b1;
                        w_stateNext    = ST_ENTRY;
                        w_idxNext      = '0;
                    end else begin
                        w_idxNext = r_idx + IW'(1);
                    end
                end else if (r_idx != '0) begin
                    if (r_idle == OW'(TIMEOUT_CYCLES - 1)) begin
                        w_stateNext = ST_ENTRY;
                        w_idxNext   = '0;
                        w_idleNext  = '0;
                    end else begin
                        w_idleNext = r_idle + OW'(1);
                    end
                end
            end
`endif
            default: begin
                w_stateNext = ST_ENTRY;
            end
        endcase
    end
endmodule

// File: tb/tb_digital_lock_param.sv
// Scoreboard bench for digital_lock_param: a digit-list reference model predicts outputs each cycle.
// Honours DIGITAL_LOCK_PROG_EN when the design is built with it.
module tb_digital_lock_param;
    localparam int           DIGIT_W        = 3;
    localparam int           CODE_LEN       = 3;
    localparam logic [8:0]   CODE           = 9'b011_111_101;
    localparam int           MAX_FAILS      = 3;
    localparam int           UNLOCK_CYCLES  = 4;
    localparam int           LOCKOUT_CYCLES = 16;
    localparam int           TIMEOUT_CYCLES = 64;

    logic clk = 1'b0;
    logic reset_n;

    digital_lock_param_if #(.DIGIT_W(DIGIT_W), .MAX_FAILS(MAX_FAILS)) bus ();

    digital_lock_param #(
        .DIGIT_W(DIGIT_W), .CODE_LEN(CODE_LEN), .CODE(CODE), .MAX_FAILS(MAX_FAILS),
        .UNLOCK_CYCLES(UNLOCK_CYCLES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef enum {M_ENTRY, M_UNLOCK, M_LOCKOUT, M_PROG} mode_t;
    typedef struct {
        int y;
        int alarm;
        int fails;
        int progDone;
    } exp_t;

    exp_t  expQ[$];
    int    checks = 0;
    int    errors = 0;

    mode_t mMode;
    int    mEntered[$];
    int    mIdle;
    int    mFails;
    int    mRemain;
    int    mProgDone;
    int    mCode[CODE_LEN];

    function automatic void modelReset();
        logic [8:0] c;
        c = CODE;
        mMode     = M_ENTRY;
        mEntered.delete();
        mIdle     = 0;
        mFails    = 0;
        mRemain   = 0;
        mProgDone = 0;
        for (int i = 0; i < CODE_LEN; i++) begin
            mCode[i] = int'(c[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W]);
        end
    endfunction

    function automatic bit enteredMatches();
        for (int i = 0; i < CODE_LEN; i++) begin
            if (mEntered[i] != mCode[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock edge of the lock, described as digit lists and countdowns
    function automatic void modelStep(input bit v, input int d, input bit p);
        mProgDone = 0;
        case (mMode)
            M_ENTRY: begin
                if (v) begin
                    mEntered.push_back(d);
                    mIdle = 0;
                    if (mEntered.size() == CODE_LEN) begin
                        if (enteredMatches()) begin
                            mMode   = M_UNLOCK;
                            mRemain = UNLOCK_CYCLES;
                            mFails  = 0;
                        end else begin
                            mFails++;
                            if (mFails == MAX_FAILS) begin
                                mMode   = M_LOCKOUT;
                                mRemain = LOCKOUT_CYCLES;
                            end
                        end
                        mEntered.delete();
                    end
                end else if (mEntered.size() > 0) begin
                    mIdle++;
                    if (mIdle == TIMEOUT_CYCLES) begin
                        mEntered.delete();
                        mIdle = 0;
                    end
                end
            end
            M_UNLOCK: begin
`ifdef DIGITAL_LOCK_PROG_EN
                if (p) begin
                    mMode = M_PROG;
                    mEntered.delete();
                    mIdle = 0;
                end else
`endif
                begin
                    mRemain--;
                    if (mRemain == 0) mMode = M_ENTRY;
                end
            end
            M_LOCKOUT: begin
                mRemain--;
                if (mRemain == 0) begin
                    mMode  = M_ENTRY;
                    mFails = 0;
                end
            end
            M_PROG: begin
                if (v) begin
                    mEntered.push_back(d);
                    mIdle = 0;
                    if (mEntered.size() == CODE_LEN) begin
                        for (int i = 0; i < CODE_LEN; i++) mCode[i] = mEntered[i];
                        mEntered.delete();
                        mProgDone = 1;
                        mMode     = M_ENTRY;
                    end
                end else if (mEntered.size() > 0) begin
                    mIdle++;
                    if (mIdle == TIMEOUT_CYCLES) begin
                        mEntered.delete();
                        mIdle = 0;
                        mMode = M_ENTRY;
                    end
                end
            end
            default: mMode = M_ENTRY;
        endcase
    endfunction

    function automatic exp_t modelOutputs();
        exp_t e;
        e.y        = (mMode == M_UNLOCK)  ? 1 : 0;
        e.alarm    = (mMode == M_LOCKOUT) ? 1 : 0;
        e.fails    = mFails;
        e.progDone = mProgDone;
        return e;
    endfunction

    task automatic checkOutput(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic cycle(input bit v, input int d, input bit p);
        @(negedge clk);
        bus.x_valid = v;
        bus.x       = DIGIT_W'(d);
`ifdef DIGITAL_LOCK_PROG_EN
        bus.prog_req = p;
`endif
        modelStep(v, d, p);
        expQ.push_back(modelOutputs());
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, 0, 1'b0);
    endtask

    task automatic applyStimulus(input int a, input int b, input int c, input int gap);
        cycle(1'b1, a, 1'b0);
        idle(gap);
        cycle(1'b1, b, 1'b0);
        idle(gap);
        cycle(1'b1, c, 1'b0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        #2;
        reset_n     = 1'b0;
        bus.x_valid = 1'b0;
`ifdef DIGITAL_LOCK_PROG_EN
        bus.prog_req = 1'b0;
`endif
        #1;
        modelReset();
        checkOutput("async_reset_y", int'(bus.y), 0);
        checkOutput("async_reset_alarm", int'(bus.alarm), 0);
        checkOutput("async_reset_fail_cnt", int'(bus.fail_cnt), 0);
        @(negedge clk);
        expQ.push_back(modelOutputs());
        @(negedge clk);
        reset_n = 1'b1;
        modelStep(1'b0, 0, 1'b0);
        expQ.push_back(modelOutputs());
    endtask

    // Monitor: every edge that has a prediction queued is compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("y", int'(bus.y), e.y);
                checkOutput("alarm", int'(bus.alarm), e.alarm);
                checkOutput("fail_cnt", int'(bus.fail_cnt), e.fails);
`ifdef DIGITAL_LOCK_PROG_EN
                checkOutput("prog_done", int'(bus.prog_done), e.progDone);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int kind;
        reset_n     = 1'b0;
        bus.x       = '0;
        bus.x_valid = 1'b0;
`ifdef DIGITAL_LOCK_PROG_EN
        bus.prog_req = 1'b0;
`endif
        modelReset();
        #1;
        checkOutput("reset_y", int'(bus.y), 0);
        checkOutput("reset_alarm", int'(bus.alarm), 0);
        checkOutput("reset_fail_cnt", int'(bus.fail_cnt), 0);
        @(negedge clk);
        reset_n = 1'b1;
        modelStep(1'b0, 0, 1'b0);
        expQ.push_back(modelOutputs());

        $display("[TB] correct code");
        applyStimulus(3, 7, 5, 0);
        idle(8);

        $display("[TB] one bad code then correct");
        applyStimulus(3, 2, 5, 1);
        idle(2);
        applyStimulus(3, 7, 5, 0);
        idle(6);

        $display("[TB] lockout after three failures");
        repeat (3) applyStimulus(0, 0, 0, 0);
        applyStimulus(3, 7, 5, 0);
        idle(20);

        $display("[TB] partial entry timeout");
        cycle(1'b1, 3, 1'b0);
        idle(TIMEOUT_CYCLES);
        cycle(1'b1, 7, 1'b0);
        cycle(1'b1, 5, 1'b0);
        idle(TIMEOUT_CYCLES + 6);

        $display("[TB] reset during unlock");
        applyStimulus(3, 7, 5, 0);
        idle(1);
        resetDut();
        applyStimulus(3, 7, 5, 0);
        idle(6);

`ifdef DIGITAL_LOCK_PROG_EN
        $display("[TB] reprogram code");
        applyStimulus(3, 7, 5, 0);
        cycle(1'b0, 0, 1'b1);
        applyStimulus(1, 2, 4, 0);
        idle(2);
        applyStimulus(3, 7, 5, 0);
        idle(2);
        applyStimulus(1, 2, 4, 0);
        idle(6);
`endif

        $display("[TB] randomized entries");
        for (int n = 0; n < 80; n++) begin
            kind = int'($urandom_range(0, 9));
            if (kind <= 4) begin
                applyStimulus(mCode[0], mCode[1], mCode[2], int'($urandom_range(0, 3)));
            end else if (kind <= 7) begin
                applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            end else if (kind == 8) begin
                repeat (int'($urandom_range(1, 2))) cycle(1'b1, int'($urandom_range(0, 7)), 1'b0);
                idle(TIMEOUT_CYCLES + 6);
            end else begin
                applyStimulus(mCode[0], mCode[1], mCode[2], 0);
                cycle(1'b0, 0, 1'($urandom_range(0, 1)));
                applyStimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                              int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
            end
            idle(int'($urandom_range(0, 5)));
        end

        idle(3);
        @(posedge clk);
        #2;
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
